// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan controller: widths, FSM state type
// and a small bit-insert helper used by the capture path.
package mux_scan_pkg;

    localparam int SEL_W  = 3;
    localparam int DATA_W = 2 ** SEL_W;

    // Last select value of a scan; the FSM leaves SCAN after sampling it.
    localparam logic [SEL_W-1:0] SEL_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // Returns word with bit idx replaced by b.
    function automatic logic [DATA_W-1:0] set_bit(
        input logic [DATA_W-1:0] word,
        input logic [SEL_W-1:0]  idx,
        input logic              b
    );
        logic [DATA_W-1:0] r;
        r      = word;
        r[idx] = b;
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_hold_cnt.sv
// Hold-time down-counter for the scan controller.
// Counts HOLD_CYC enabled cycles per select value; 'tick' is high during the
// last enabled cycle of each hold window, which is the cycle y is sampled in.
// 'clear' reloads the counter so a fresh scan starts a full window.
module mux_scan_hold_cnt #(
    parameter int HOLD_CYC = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Down-count while enabled, reloading after the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (clear) begin
            cnt <= RELOAD;
        end else if (en) begin
            if (cnt == '0) begin
                cnt <= RELOAD;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequential feeder/collector around an 8:1 bit mux.
// Accepts a word (valid/ready), drives it on mux_a, steps mux_s 0..7 holding
// each value HOLD_CYC cycles, samples mux_y into out_data[mux_s], then offers
// the rebuilt word on a valid/ready output.
// Optional build macro: MUX_SCAN_CHECK_EN adds a sticky scan_err flag that is
// set when the rebuilt word differs from mux_a; otherwise scan_err is tied 0.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and a producer keeps valid and
// data stable until that transfer edge.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int HOLD_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] mux_a,
    output logic [SEL_W-1:0]  mux_s,
    input  logic              mux_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              scan_err,
    output scan_state_t       dbg_state
);

    scan_state_t       state;
    scan_state_t       next_state;
    logic              accept;
    logic              scan_en;
    logic              tick;
    logic              last_sample;
    logic              in_ready_c;
    logic              out_valid_c;
    logic              busy_c;
    logic [DATA_W-1:0] captured;

    // Decodes kept outside the FSM block so the counter's tick can feed
    // next-state logic without forming a block-level loop.
    assign scan_en     = (state == SCAN);
    assign accept      = (state == IDLE) && in_valid && rst_n;
    assign last_sample = scan_en && tick && (mux_s == SEL_MAX);
    assign captured    = set_bit(out_data, mux_s, mux_y);

    mux_scan_hold_cnt #(
        .HOLD_CYC (HOLD_CYC)
    ) u_hold_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .en    (scan_en),
        .tick  (tick)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    next_state = SCAN;
                end
            end
            SCAN: begin
                busy_c = 1'b1;
                if (last_sample) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy_c      = 1'b1;
                out_valid_c = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // in_ready is masked by rst_n so it reads 0 while reset is asserted even
    // though the state register already sits in IDLE.
    assign in_ready  = in_ready_c && rst_n;
    assign out_valid = out_valid_c;
    assign busy      = busy_c;
    assign dbg_state = state;

    // Mux drive and capture path: load on accept, sample on each tick,
    // park select at 0 while the result waits in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_a    <= '0;
            mux_s    <= '0;
            out_data <= '0;
        end else if (accept) begin
            mux_a    <= in_data;
            mux_s    <= '0;
            out_data <= '0;
        end else if (scan_en && tick) begin
            out_data <= captured;
            if (mux_s != SEL_MAX) begin
                mux_s <= mux_s + SEL_W'(1);
            end
        end else if (state == DONE) begin
            mux_s <= '0;
        end
    end

`ifdef MUX_SCAN_CHECK_EN
    // Sticky compare of the completed word against the driven word, taken on
    // the edge that enters DONE (the final bit is still in flight on mux_y).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_err <= 1'b0;
        end else if (last_sample && (captured != mux_a)) begin
            scan_err <= 1'b1;
        end
    end
`else
    assign scan_err = 1'b0;
`endif

endmodule
